// File: rtl/fp32_normalize_pack.sv
// fp32_normalize_pack: normalizes, rounds and packs an FP32 add/sub mantissa sum over valid/ready.
module fp32_normalize_pack #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow
);
    typedef enum logic [1:0] {IDLE, CHECK, SHIFT_L, DONE} state_t;
    localparam logic [EXP_W:0] E_ONE = 1;
    localparam logic [EXP_W:0] E_MAX = (1 << EXP_W) - 1;

    state_t            state_q, state_d;
    logic              sign_q, sign_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [EXP_W:0]    exp_q, exp_d, ecar, es;
    logic [MANT_W:0]   m_q, m_d, rnd, car, ms;
    logic [31:0]       res_q, res_d, inf;

    function automatic logic [31:0] pack(input logic s, input logic [EXP_W:0] e, input logic [MANT_W:0] m);
        return m[MANT_W-1] ? {s, e[EXP_W-1:0], m[MANT_W-2:0]} : {s, {EXP_W{1'b0}}, m[MANT_W-2:0]};
    endfunction

    assign rnd  = (m_q >> 1) + (MANT_W+1)'(m_q[0] & m_q[1]);
    assign car  = rnd[MANT_W] ? rnd >> 1 : rnd;
    assign ecar = exp_q + E_ONE + (EXP_W+1)'(rnd[MANT_W]);
    assign ms   = m_q << 1;
    assign es   = exp_q - E_ONE;
    assign inf  = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        m_d     = m_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d  = in_sign;
                exp_d   = (in_exp == '0) ? E_ONE : {1'b0, in_exp};
                m_d     = in_mant;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                state_d = CHECK;
            end
            CHECK: begin
                state_d = DONE;
                if (exp_q == E_MAX)
                    res_d = inf;
                else if (m_q == '0)
                    res_d = '0;
                else if (m_q[MANT_W]) begin
                    ovf_d = ecar >= E_MAX;
                    res_d = (ecar >= E_MAX) ? inf : pack(sign_q, ecar, car);
                end else if (m_q[MANT_W-1] || exp_q == E_ONE) begin
                    res_d = pack(sign_q, exp_q, m_q);
                    unf_d = !m_q[MANT_W-1];
                end else
                    state_d = SHIFT_L;
            end
            SHIFT_L: begin
                m_d   = ms;
                exp_d = es;
                if (ms[MANT_W-1] || es == E_ONE) begin
                    res_d   = pack(sign_q, es, ms);
                    unf_d   = !ms[MANT_W-1];
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            m_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            m_q     <= m_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready      = state_q == IDLE;
    assign out_valid     = state_q == DONE;
    assign out_result    = res_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
endmodule

// File: tb/tb_fp32_normalize_pack.sv
// tb_fp32_normalize_pack: directed vectors with hand-computed results, latency, backpressure and reset checks.
module tb_fp32_normalize_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    int          checks = 0;
    int          passes = 0;

    fp32_normalize_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    task automatic start(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m);
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign  = 1'b1;
        in_exp   = 8'hAA;
        in_mant  = 25'h155_5555;
    endtask

    task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                       input logic [31:0] r, input logic ov, input logic un, input int lat);
        int n;
        start(tag, s, e, m);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, out_result, r);
        chk({tag, " overflow"}, 32'(out_overflow), 32'(ov));
        chk({tag, " underflow"}, 32'(out_underflow), 32'(un));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_result", out_result, 32'h0);
        chk("reset flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("carry 2.0", 1'b0, 8'd127, 25'h100_0000, 32'h4000_0000, 1'b0, 1'b0, 2);
        consume("carry 2.0");
        run("zero", 1'b1, 8'd140, 25'h000_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
        consume("zero");
        run("shift2", 1'b0, 8'd130, 25'h020_0000, 32'h4000_0000, 1'b0, 1'b0, 4);
        consume("shift2");
        run("tie up", 1'b0, 8'd127, 25'h100_0003, 32'h4000_0002, 1'b0, 1'b0, 2);
        consume("tie up");
        run("tie even", 1'b0, 8'd127, 25'h100_0001, 32'h4000_0000, 1'b0, 1'b0, 2);
        consume("tie even");
        run("round carry", 1'b0, 8'd127, 25'h1FF_FFFF, 32'h4080_0000, 1'b0, 1'b0, 2);
        consume("round carry");
        run("subnormal", 1'b0, 8'd3, 25'h000_0100, 32'h0000_0400, 1'b0, 1'b1, 4);
        consume("subnormal");
        run("inf/nan exp", 1'b1, 8'd255, 25'h000_0123, 32'hFF80_0000, 1'b0, 1'b0, 2);
        consume("inf/nan exp");
        run("normalized", 1'b0, 8'd100, 25'h0C0_0000, 32'h3240_0000, 1'b0, 1'b0, 2);
        consume("normalized");
        run("exp0 subnormal", 1'b1, 8'd0, 25'h000_0001, 32'h8000_0001, 1'b0, 1'b1, 2);
        consume("exp0 subnormal");
        run("max shifts", 1'b0, 8'd130, 25'h000_0001, 32'h3580_0000, 1'b0, 1'b0, 25);
        consume("max shifts");

        out_ready = 1'b0;
        run("overflow", 1'b1, 8'd254, 25'h100_0000, 32'hFF80_0000, 1'b1, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold result", out_result, 32'hFF80_0000);
            chk("hold overflow", 32'(out_overflow), 32'd1);
            chk("hold in_ready", 32'(in_ready), 32'd0);
        end
        consume("overflow");

        start("rst in shift", 1'b0, 8'd130, 25'h000_0001);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst shift out_valid", 32'(out_valid), 32'd0);
        chk("rst shift in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        out_ready = 1'b0;
        run("pre-rst done", 1'b1, 8'd254, 25'h100_0000, 32'hFF80_0000, 1'b1, 1'b0, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("rst done out_valid", 32'(out_valid), 32'd0);
        chk("rst done in_ready", 32'(in_ready), 32'd1);
        chk("rst done result", out_result, 32'h0);
        chk("rst done overflow", 32'(out_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        run("after reset", 1'b0, 8'd127, 25'h100_0003, 32'h4000_0002, 1'b0, 1'b0, 2);
        consume("after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fp32_normalize_pack.md
Name: fp32_normalize_pack

Overview:
Back end of the FP32 add/sub datapath. Takes the raw 25-bit sign-magnitude mantissa sum, the result sign from the mantissa adder, and the common biased exponent of the aligned operands. Normalizes iteratively, with one left shift per cycle, and rounds to nearest-even on the carry-out path. Packs the result as an IEEE-754 single and returns it over a valid/ready handshake.

Parameters:
EXP_W, 8, biased exponent width
MANT_W, 24, mantissa width including hidden bit (input sum is MANT_W+1 bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream has a sum to normalize
in_ready  output  1  block can accept; high only in IDLE
in_sign  input  1  sign of sum from mantissa adder
in_exp  input  EXP_W  biased exponent of aligned operands
in_mant  input  MANT_W+1  raw magnitude sum, bit 24 = carry-out
out_valid  output  1  out_result valid
out_ready  input  1  downstream accepts result
out_result  output  32  packed {sign, exp[7:0], frac[22:0]}
out_overflow  output  1  result forced to infinity by exponent overflow
out_underflow  output  1  result is a nonzero subnormal

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, out_result=0, out_overflow=0, out_underflow=0, internal regs=0. in_ready=(state==IDLE), so in_ready=1 during and after reset.
- FSM states: IDLE, CHECK, SHIFT_L, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge N, capture sign/exp/mant and go to CHECK. in_exp==0 is captured as 1 (subnormal operands).
- CHECK (cycle N+1), priority order:
  - in_exp==255: result {sign,8'hFF,0}, no flags, go to DONE.
  - mant==0: result +0 (0x00000000) regardless of sign, no flags, go to DONE.
  - mant[24]==1: guard=mant[0]; m=mant>>1; exp+=1. If guard&&m[0], then m+=1 (ties-to-even; only one bit is lost, so guard=1 is always an exact tie). If m carries to bit 24: m>>=1 (lost bit is 0), exp+=1. If exp>=255: result {sign,8'hFF,0}, out_overflow=1. Go to DONE.
  - mant[23]==1: pack directly, go to DONE.
  - Otherwise, if exp==1: pack as subnormal; else go to SHIFT_L.
- SHIFT_L: each cycle m<<=1 and exp-=1. Leave when m[23]==1 (normal pack) or exp==1 (subnormal pack), whichever comes first after the shift, then go to DONE. Takes k cycles for k shifts.
- Pack rules:
  - Normal: {sign, exp, m[22:0]}.
  - Subnormal (exp==1 and m[23]==0): {sign, 8'h00, m[22:0]}, out_underflow=1.
- DONE: out_valid=1; out_result and flags are registered and held stable while out_ready=0. On out_valid&&out_ready, go to IDLE and clear out_valid on that edge. No new input is accepted in the same cycle (in_ready=0 in DONE).
- Latency: out_valid rises at N+2 for no-shift paths (zero, carry, already normalized) and at N+2+k for k left shifts, with k≤23.
- Throughput: at most one result per 3 cycles.
- Reset mid-operation: any state returns to IDLE asynchronously, the in-flight result is discarded, and out_valid drops immediately.
- Input signals are ignored outside IDLE. Upstream must hold data only for the handshake cycle.

Test Plan:
- sign=0, exp=127, mant=0x1000000 -> out_result=0x40000000, flags 0, out_valid at N+2.
- sign=1, exp=140, mant=0x0000000 -> out_result=0x00000000 (+0), flags 0, out_valid at N+2.
- sign=0, exp=130, mant=0x0200000 -> 2 SHIFT_L cycles, out_result=0x40000000 at N+4.
- Tie-to-even on the carry path:
  - exp=127, mant=0x1000003 -> 0x40000002.
  - exp=127, mant=0x1000001 -> 0x40000000.
  - exp=127, mant=0x1FFFFFF -> round carries, out_result=0x40800000.
- Exponent overflow: exp=254, mant=0x1000000, sign=1 -> out_result=0xFF800000, out_overflow=1.
- Subnormal: exp=3, mant=0x0000100 -> 2 shifts, out_result=0x00000400, out_underflow=1 at N+4.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles: result and flags stay stable, in_ready=0.
  - Assert rst during SHIFT_L: out_valid=0 and in_ready=1 immediately.
  - A fresh transaction after reset completes correctly.
